// File: rtl/regfile_scoreboard_if.sv
// Decode-side handshake between the instruction decoder and the register-file hazard scoreboard.
// The master modport drives decoded operands and write-back; the slave modport is the scoreboard.
interface regfile_scoreboard_if #(
    parameter int unsigned STALL_W = 32
);
    logic               issue_valid;
    logic               issue_ready;
    logic               use_rn;
    logic [4:0]         rn;
    logic               use_rm;
    logic [4:0]         rm;
    logic               wr_en;
    logic [4:0]         rd;
    logic               wb_valid;
    logic [4:0]         wb_reg;
    logic               flush;
    logic               busy_any;
    logic               wb_error;
    logic [STALL_W-1:0] stall_count;

    modport master (
        output issue_valid, use_rn, rn, use_rm, rm, wr_en, rd, wb_valid, wb_reg, flush,
        input  issue_ready, busy_any, wb_error, stall_count
    );

    modport slave (
        input  issue_valid, use_rn, rn, use_rm, rm, wr_en, rd, wb_valid, wb_reg, flush,
        output issue_ready, busy_any, wb_error, stall_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Issue-side hazard controller: per-register pending-write counters that stall issue until the
// producing write-back has reached the 32x64 register file. Register 31 (XZR) is never tracked.
module regfile_scoreboard #(
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned STALL_W = 32
) (
    input logic                  clk,
    input logic                  reset_n,
    regfile_scoreboard_if.slave  bus
);

    localparam logic [CNT_W-1:0]   CntMax   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(1);
    localparam logic [STALL_W-1:0] StallMax = {STALL_W{1'b1}};
    localparam logic [4:0]         Xzr      = 5'd31;

    logic [CNT_W-1:0]   cnt_q [31];
    logic [CNT_W-1:0]   cnt_d [31];
    logic [CNT_W-1:0]   cnt_view [32];
    logic [30:0]        inc_vec;
    logic [30:0]        dec_vec;
    logic               wb_error_q, wb_error_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic rn_haz, rm_haz, rd_haz;
    logic issue_ready, accept, wb_orphan, busy;

    // XZR reads as a constant-zero counter so it can never raise a hazard.
    always_comb begin
        for (int i = 0; i < 31; i++) begin
            cnt_view[i] = cnt_q[i];
        end
        cnt_view[31] = '0;
    end

    // A source with exactly one pending write that retires this cycle is readable thanks to
    // write-before-read in the register file.
    assign rn_haz = bus.use_rn && (cnt_view[bus.rn] != '0) &&
                    !((cnt_view[bus.rn] == CntOne) && bus.wb_valid && (bus.wb_reg == bus.rn));
    assign rm_haz = bus.use_rm && (cnt_view[bus.rm] != '0) &&
                    !((cnt_view[bus.rm] == CntOne) && bus.wb_valid && (bus.wb_reg == bus.rm));
    assign rd_haz = bus.wr_en && (bus.rd != Xzr) && (cnt_view[bus.rd] == CntMax) &&
                    !(bus.wb_valid && (bus.wb_reg == bus.rd));

    assign issue_ready = !bus.flush && !rn_haz && !rm_haz && !rd_haz;
    assign accept      = bus.issue_valid && issue_ready;
    assign wb_orphan   = bus.wb_valid && (bus.wb_reg != Xzr) && (cnt_view[bus.wb_reg] == '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < 31; r++) begin
            inc_vec[r] = accept && bus.wr_en && (bus.rd == 5'(r));
            dec_vec[r] = bus.wb_valid && (bus.wb_reg == 5'(r)) && (cnt_q[r] != '0);
            cnt_d[r]   = cnt_q[r];
            if (bus.flush) begin
                cnt_d[r] = '0;
            end else if (inc_vec[r] && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + CntOne;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                cnt_d[r] = cnt_q[r] - CntOne;
            end
        end
    end

    always_comb begin
        wb_error_d = wb_error_q || (!bus.flush && wb_orphan);
        stall_d    = stall_q;
        if (bus.issue_valid && !issue_ready && (stall_q != StallMax)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < 31; i++) begin
            busy = busy || (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 31; i++) begin
                cnt_q[i] <= '0;
            end
            wb_error_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            for (int i = 0; i < 31; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            wb_error_q <= wb_error_d;
            stall_q    <= stall_d;
        end
    end

    assign bus.issue_ready = issue_ready;
    assign bus.busy_any    = busy;
    assign bus.wb_error    = wb_error_q;
    assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: hand-computed expectations for hazards, XZR handling,
// saturation, flush, sticky write-back error and asynchronous reset.
module tb_regfile_scoreboard;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    regfile_scoreboard_if #(.STALL_W(32)) bus ();

    regfile_scoreboard #(
        .CNT_W   (2),
        .STALL_W (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.use_rn      = 1'b0;
        bus.rn          = 5'd0;
        bus.use_rm      = 1'b0;
        bus.rm          = 5'd0;
        bus.wr_en       = 1'b0;
        bus.rd          = 5'd0;
        bus.wb_valid    = 1'b0;
        bus.wb_reg      = 5'd0;
        bus.flush       = 1'b0;
    endtask

    // Advance one edge, then settle away from it; inputs return to idle.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic issue_wr(input logic [4:0] r);
        bus.issue_valid = 1'b1;
        bus.wr_en       = 1'b1;
        bus.rd          = r;
        #1;
    endtask

    task automatic wb(input logic [4:0] r);
        bus.wb_valid = 1'b1;
        bus.wb_reg   = r;
        #1;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        idle();
        reset_n = 1'b0;
        #12;
        check_eq("rst_busy", 64'(bus.busy_any), 64'd0);
        check_eq("rst_err", 64'(bus.wb_error), 64'd0);
        check_eq("rst_stall", 64'(bus.stall_count), 64'd0);
        check_eq("rst_ready", 64'(bus.issue_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #2;

        // RAW on r5, resolved by same-cycle write-back
        issue_wr(5'd5);
        check_eq("t1_wr_ready", 64'(bus.issue_ready), 64'd1);
        step();
        check_eq("t1_busy", 64'(bus.busy_any), 64'd1);
        for (int i = 0; i < 2; i++) begin
            bus.issue_valid = 1'b1; bus.use_rn = 1'b1; bus.rn = 5'd5; #1;
            check_eq("t1_raw_stall", 64'(bus.issue_ready), 64'd0);
            step();
            check_eq("t1_stall_cnt", 64'(bus.stall_count), 64'(i + 1));
        end
        bus.issue_valid = 1'b1; bus.use_rn = 1'b1; bus.rn = 5'd5;
        wb(5'd5);
        check_eq("t1_bypass_ready", 64'(bus.issue_ready), 64'd1);
        step();
        check_eq("t1_drained", 64'(bus.busy_any), 64'd0);
        check_eq("t1_stall_hold", 64'(bus.stall_count), 64'd2);

        // Saturate r7 at 3 pending writes
        for (int i = 0; i < 3; i++) begin
            issue_wr(5'd7);
            check_eq("t2_wr_ready", 64'(bus.issue_ready), 64'd1);
            step();
        end
        issue_wr(5'd7);
        check_eq("t2_sat_stall", 64'(bus.issue_ready), 64'd0);
        step();
        check_eq("t2_stall_cnt", 64'(bus.stall_count), 64'd3);
        issue_wr(5'd7);
        wb(5'd7);
        check_eq("t2_sat_wb_ready", 64'(bus.issue_ready), 64'd1);
        step();
        issue_wr(5'd7);
        check_eq("t2_still_sat", 64'(bus.issue_ready), 64'd0);
        step();
        check_eq("t2_stall_cnt2", 64'(bus.stall_count), 64'd4);
        for (int i = 0; i < 3; i++) begin
            wb(5'd7);
            step();
        end
        check_eq("t2_drained", 64'(bus.busy_any), 64'd0);
        check_eq("t2_no_err", 64'(bus.wb_error), 64'd0);

        // XZR never tracked
        issue_wr(5'd31);
        check_eq("t3_xzr_wr", 64'(bus.issue_ready), 64'd1);
        step();
        check_eq("t3_xzr_busy", 64'(bus.busy_any), 64'd0);
        issue_wr(5'd31);
        bus.use_rn = 1'b1; bus.rn = 5'd31; bus.use_rm = 1'b1; bus.rm = 5'd31;
        wb(5'd31);
        check_eq("t3_xzr_src", 64'(bus.issue_ready), 64'd1);
        step();
        check_eq("t3_xzr_busy2", 64'(bus.busy_any), 64'd0);
        check_eq("t3_xzr_wb_err", 64'(bus.wb_error), 64'd0);

        // Same-edge inc/dec on r9 leaves count at 1
        issue_wr(5'd9);
        step();
        issue_wr(5'd9);
        wb(5'd9);
        check_eq("t4_ready", 64'(bus.issue_ready), 64'd1);
        step();
        check_eq("t4_busy", 64'(bus.busy_any), 64'd1);
        check_eq("t4_no_err", 64'(bus.wb_error), 64'd0);
        bus.issue_valid = 1'b1; bus.use_rm = 1'b1; bus.rm = 5'd9; #1;
        check_eq("t4_rm_stall", 64'(bus.issue_ready), 64'd0);
        wb(5'd9);
        check_eq("t4_rm_bypass", 64'(bus.issue_ready), 64'd1);
        step();
        check_eq("t4_drained", 64'(bus.busy_any), 64'd0);
        check_eq("t4_stall_cnt", 64'(bus.stall_count), 64'd4);

        // Flush with r3=2, r4=1; orphan wb during flush is ignored
        issue_wr(5'd3); step();
        issue_wr(5'd3); step();
        issue_wr(5'd4); step();
        issue_wr(5'd10);
        bus.flush = 1'b1;
        wb(5'd12);
        check_eq("t5_flush_ready", 64'(bus.issue_ready), 64'd0);
        step();
        check_eq("t5_flush_busy", 64'(bus.busy_any), 64'd0);
        check_eq("t5_flush_err", 64'(bus.wb_error), 64'd0);
        check_eq("t5_flush_stall", 64'(bus.stall_count), 64'd5);
        wb(5'd3);
        step();
        check_eq("t5_orphan_err", 64'(bus.wb_error), 64'd1);
        check_eq("t5_orphan_busy", 64'(bus.busy_any), 64'd0);
        bus.flush = 1'b1; #1;
        step();
        step();
        check_eq("t5_err_sticky", 64'(bus.wb_error), 64'd1);

        // Build stall_count=12 with busy, then reset between edges
        issue_wr(5'd2);
        step();
        for (int i = 0; i < 7; i++) begin
            bus.issue_valid = 1'b1; bus.use_rn = 1'b1; bus.rn = 5'd2; #1;
            step();
        end
        check_eq("t6_pre_stall", 64'(bus.stall_count), 64'd12);
        check_eq("t6_pre_busy", 64'(bus.busy_any), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("t6_async_busy", 64'(bus.busy_any), 64'd0);
        check_eq("t6_async_stall", 64'(bus.stall_count), 64'd0);
        check_eq("t6_async_err", 64'(bus.wb_error), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        issue_wr(5'd1);
        check_eq("t6_post_ready", 64'(bus.issue_ready), 64'd1);
        step();
        check_eq("t6_post_busy", 64'(bus.busy_any), 64'd1);
        check_eq("t6_post_stall", 64'(bus.stall_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
